// File: rtl/mac_sequencer.sv
// Sum of four products through one shared multiplier; done lands 4*(1+L)+1 cycles after start.
// No input backpressure: start is only accepted in IDLE; the block stalls indefinitely on mul_done.
module mac_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic [WIDTH-1:0] i8,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_p
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  state_t           state, state_nxt;
  pair_t            bank [4];
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic             accept;
  logic             capture;
  logic             last;

  assign sum     = acc + mul_p;
  assign idx_nxt = idx + 2'd1;
  assign last    = (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // a mul_done seen here belongs to no request of ours and is dropped
        mul_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          capture   = 1'b1;
          state_nxt = last ? DONE : ISSUE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mul_a/mul_b are loaded on the edge entering ISSUE so they are valid alongside mul_start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) bank[k] <= '0;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
    end else if (accept) begin
      bank[0] <= '{a: i1, b: i2};
      bank[1] <= '{a: i3, b: i4};
      bank[2] <= '{a: i5, b: i6};
      bank[3] <= '{a: i7, b: i8};
      acc     <= '0;
      idx     <= '0;
      mul_a   <= i1;
      mul_b   <= i2;
    end else if (capture) begin
      acc <= sum;
      if (last) begin
        result <= sum;
      end else begin
        idx   <= idx_nxt;
        mul_a <= bank[idx_nxt].a;
        mul_b <= bank[idx_nxt].b;
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural variable-latency multiplier.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] i1, i2, i3, i4, i5, i6, i7, i8;
  logic [31:0] result;
  logic        done, busy, mul_start;
  logic [31:0] mul_a, mul_b;
  logic        mul_done;
  logic [31:0] mul_p;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat  = 1;
  int          pend = 0;
  logic [31:0] pa, pb;

  int nstart_p, ndone_p, nbusy, nstab_err, held_err;
  logic        inw = 1'b0;
  logic [31:0] cap_a, cap_b;

  mac_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7), .i8(i8),
    .result(result), .done(done), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p)
  );

  always #5 clk = ~clk;

  // Multiplier: answers exactly lat cycles after the mul_start cycle, garbage product otherwise.
  initial begin
    mul_done = 1'b0;
    mul_p    = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      mul_done = 1'b0;
      mul_p    = 32'hDEAD_BEEF;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          mul_done = 1'b1;
          mul_p    = pa * pb;
        end
      end
      if (mul_start) begin
        pa   = mul_a;
        pb   = mul_b;
        pend = lat;
      end
    end
  end

  // Activity monitor, sampled mid-cycle.
  initial begin
    nstart_p = 0; ndone_p = 0; nbusy = 0; nstab_err = 0;
    forever begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) ndone_p++;
      if (rst) begin
        inw = 1'b0;
      end else if (mul_start) begin
        nstart_p++;
        cap_a = mul_a;
        cap_b = mul_b;
        inw   = 1'b1;
      end else if (inw) begin
        if (mul_a !== cap_a || mul_b !== cap_b) nstab_err++;
        if (mul_done) inw = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_ops(input logic [31:0] a, b, c, d, e, f, g, h);
    i1 = a; i2 = b; i3 = c; i4 = d; i5 = e; i6 = f; i7 = g; i8 = h;
  endtask

  // Starts one computation; returns the cycle (relative to acceptance) at which done was seen.
  task automatic run_one(input logic noise, output int dcyc);
    logic [31:0] held;
    held     = result;
    dcyc     = 0;
    held_err = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    nstart_p = 0; ndone_p = 0; nbusy = 0; nstab_err = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (!noise && n == 1) start = 1'b0;
      if (noise && n == 3) set_ops(9, 9, 9, 9, 9, 9, 9, 9);
      if (noise && n >= 8) start = 1'b0;
      if (done) begin
        dcyc = n;
        break;
      end
      if (result !== held) held_err++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    n_cmp++; if (result !== 32'd0)  begin n_bad++; $display("FAIL reset_result: got %0h, expected 0", result); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b, expected 0", done); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_cmp++; if (mul_start !== 1'b0) begin n_bad++; $display("FAIL reset_mul_start: got %b, expected 0", mul_start); end
    n_cmp++; if (mul_a !== 32'd0)   begin n_bad++; $display("FAIL reset_mul_a: got %0h, expected 0", mul_a); end
    n_cmp++; if (mul_b !== 32'd0)   begin n_bad++; $display("FAIL reset_mul_b: got %0h, expected 0", mul_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_l1();
    int dc;
    lat = 1;
    set_ops(2, 2, 2, 2, 3, 2, 1, 1);
    run_one(1'b0, dc);
    n_cmp++; if (result !== 32'd15) begin n_bad++; $display("FAIL l1_result: got %0d, expected 15", result); end
    n_cmp++; if (dc != 9) begin n_bad++; $display("FAIL l1_done_cycle: got %0d, expected 9", dc); end
    repeat (3) @(negedge clk);
    n_cmp++; if (ndone_p != 1) begin n_bad++; $display("FAIL l1_done_pulses: got %0d, expected 1", ndone_p); end
    n_cmp++; if (nbusy != 9) begin n_bad++; $display("FAIL l1_busy_cycles: got %0d, expected 9", nbusy); end
    n_cmp++; if (nstart_p != 4) begin n_bad++; $display("FAIL l1_mul_starts: got %0d, expected 4", nstart_p); end
  endtask

  task automatic test_basic_l5();
    int dc;
    lat = 5;
    set_ops(2, 2, 2, 2, 3, 2, 1, 1);
    run_one(1'b0, dc);
    n_cmp++; if (result !== 32'd15) begin n_bad++; $display("FAIL l5_result: got %0d, expected 15", result); end
    n_cmp++; if (dc != 25) begin n_bad++; $display("FAIL l5_done_cycle: got %0d, expected 25", dc); end
    repeat (3) @(negedge clk);
    n_cmp++; if (nstart_p != 4) begin n_bad++; $display("FAIL l5_mul_starts: got %0d, expected 4", nstart_p); end
    n_cmp++; if (nstab_err != 0) begin n_bad++; $display("FAIL l5_operand_stability: got %0d unstable cycles, expected 0", nstab_err); end
    n_cmp++; if (nbusy != 25) begin n_bad++; $display("FAIL l5_busy_cycles: got %0d, expected 25", nbusy); end
  endtask

  task automatic test_wrap();
    int dc;
    lat = 3;
    set_ops(32'h0001_0000, 32'h0001_0000, 3, 4, 0, 9, 32'hFFFF_FFFF, 1);
    run_one(1'b0, dc);
    n_cmp++; if (result !== 32'h0000_000B) begin n_bad++; $display("FAIL wrap_result: got %0h, expected b", result); end
    n_cmp++; if (dc != 17) begin n_bad++; $display("FAIL wrap_done_cycle: got %0d, expected 17", dc); end
    n_cmp++; if (held_err != 0) begin n_bad++; $display("FAIL wrap_prev_result_held: got %0d changes, expected 0", held_err); end
  endtask

  task automatic test_start_while_busy();
    int dc;
    lat = 1;
    set_ops(2, 2, 2, 2, 3, 2, 1, 1);
    run_one(1'b1, dc);
    n_cmp++; if (result !== 32'd15) begin n_bad++; $display("FAIL busy_start_result: got %0d, expected 15", result); end
    n_cmp++; if (dc != 9) begin n_bad++; $display("FAIL busy_start_done_cycle: got %0d, expected 9", dc); end
    repeat (4) @(negedge clk);
    n_cmp++; if (ndone_p != 1) begin n_bad++; $display("FAIL busy_start_done_pulses: got %0d, expected 1", ndone_p); end
    n_cmp++; if (nbusy != 9) begin n_bad++; $display("FAIL busy_start_busy_cycles: got %0d, expected 9", nbusy); end
  endtask

  task automatic test_reset_mid_run();
    int dc;
    lat = 5;
    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    nstart_p = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    n_cmp++; if (nstart_p != 2) begin n_bad++; $display("FAIL rst_mid_in_second_wait: got %0d mul_starts, expected 2", nstart_p); end
    rst = 1'b1;
    #1;
    n_cmp++; if (result !== 32'd0)   begin n_bad++; $display("FAIL rst_mid_result: got %0h, expected 0", result); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_mid_busy: got %b, expected 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL rst_mid_done: got %b, expected 0", done); end
    n_cmp++; if (mul_start !== 1'b0) begin n_bad++; $display("FAIL rst_mid_mul_start: got %b, expected 0", mul_start); end
    n_cmp++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin n_bad++; $display("FAIL rst_mid_mul_ops: got %0h/%0h, expected 0/0", mul_a, mul_b); end
    @(negedge clk);
    rst = 1'b0;
    ndone_p = 0; nbusy = 0; nstart_p = 0;
    repeat (6) @(negedge clk);
    n_cmp++; if (nbusy != 0 || ndone_p != 0 || nstart_p != 0) begin n_bad++; $display("FAIL rst_mid_late_mul_done: got busy=%0d done=%0d starts=%0d, expected 0/0/0", nbusy, ndone_p, nstart_p); end
    n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL rst_mid_result_after: got %0h, expected 0", result); end
    lat = 1;
    set_ops(2, 2, 2, 2, 3, 2, 1, 1);
    run_one(1'b0, dc);
    n_cmp++; if (result !== 32'd15) begin n_bad++; $display("FAIL rst_mid_rerun_result: got %0d, expected 15", result); end
    n_cmp++; if (dc != 9) begin n_bad++; $display("FAIL rst_mid_rerun_done_cycle: got %0d, expected 9", dc); end
  endtask

  task automatic test_back_to_back();
    int dc;
    lat = 1;
    set_ops(2, 2, 2, 2, 3, 2, 1, 1);
    run_one(1'b0, dc);
    n_cmp++; if (result !== 32'd15) begin n_bad++; $display("FAIL b2b_first_result: got %0d, expected 15", result); end
    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    run_one(1'b0, dc);
    n_cmp++; if (result !== 32'd100) begin n_bad++; $display("FAIL b2b_second_result: got %0d, expected 100", result); end
    n_cmp++; if (dc != 9) begin n_bad++; $display("FAIL b2b_second_done_cycle: got %0d, expected 9", dc); end
    n_cmp++; if (held_err != 0) begin n_bad++; $display("FAIL b2b_first_result_held: got %0d changes, expected 0", held_err); end
  endtask

  initial begin
    test_reset();
    test_basic_l1();
    test_basic_l5();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
